// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller around a one-bit full adder

// One-bit full adder cell shared by the serial datapath
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] part;
    logic [WIDTH-1:0] part_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // The partial register keeps WIDTH-1 bits; the newest sum bit completes it
    assign part_next = {fa_s, part};
    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign last_bit  = (state == S_RUN) && (cnt == LAST_BIT);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; back-to-back start is taken directly from DONE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST_BIT) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latching, serial shift/carry chain and result capture at the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= A;
            op_b  <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            part  <= part_next[WIDTH-1:1];
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                // carry still holds the carry into the MSB at this edge
                Sum  <= part_next;
                Cout <= fa_co;
                Ovf  <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        longint sa, sbv, r, ur;
        logic [W-1:0] s;
        logic co, ov;
        sa  = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
        sbv = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
        if (!sb) begin
            ur = longint'(a) + longint'(b) + longint'(ci);
            s  = W'(ur);
            co = (ur >= (longint'(1) << W));
            r  = sa + sbv + longint'(ci);
        end else begin
            s  = a - b;
            co = (a >= b);
            r  = sa - sbv;
        end
        ov = (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
        return {ov, co, s};
    endfunction

    // One operation: start pulse, busy window checks, result check, done pulse width
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, input bit mid_start, input string tag);
        logic [W+1:0] exp;
        int  n;
        bit  held_ok;
        exp = model(a, b, ci, sb);
        @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        held_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy || Sum !== prev_sum || Cout !== prev_cout || Ovf !== prev_ovf)
                held_ok = 1'b0;
            if (mid_start && n == 2) begin
                start = 1'b1; A = 8'hAA; B = 8'hAA; sub = 1'b0; Cin = 1'b0;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(W));
        check({tag, "_held"}, 64'(held_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(Sum), 64'(exp[W-1:0]));
        check({tag, "_cout"}, 64'(Cout), 64'(exp[W]));
        check({tag, "_ovf"}, 64'(Ovf), 64'(exp[W+1]));
        prev_sum = exp[W-1:0]; prev_cout = exp[W]; prev_ovf = exp[W+1];
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  cyc, last, pulses;
        bit  no_done;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(Sum), 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        check("rst_ovf", 64'(Ovf), 64'd0);
        rst_n = 1'b1;

        do_op(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, "add_3c_5a");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, "add_7f_cin");
        do_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, "sub_10_20");
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, "sub_80_01");
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, "ignored_start");

        // Continuous start: done every WIDTH+1 cycles, busy right after each done
        @(negedge clk);
        A = 8'h05; B = 8'h03; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        cyc = 0; last = -1; pulses = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("b2b_sum", 64'(Sum), 64'h08);
                check("b2b_busy_low", 64'(busy), 64'd0);
                if (last >= 0) check("b2b_period", 64'(cyc - last), 64'(W + 1));
                last = cyc;
                pulses++;
                @(negedge clk);
                cyc++;
                check("b2b_busy_again", 64'(busy), 64'd1);
            end
        end
        check("b2b_pulses", 64'(pulses), 64'd3);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_drain", 64'(done), 64'd1);
        prev_sum = 8'h08; prev_cout = 1'b0; prev_ovf = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN aborts without a done pulse
        A = 8'hC3; B = 8'h7E; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(Sum), 64'd0);
        check("abort_cout", 64'(Cout), 64'd0);
        check("abort_ovf", 64'(Ovf), 64'd0);
        no_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) no_done = 1'b0;
        end
        check("abort_no_done", 64'(no_done), 64'd1);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        do_op(8'h02, 8'h02, 1'b0, 1'b0, 1'b0, "after_abort");

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) rb = ra;
            do_op(ra, rb, 1'($urandom), 1'($urandom), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller. It sequences one instance of the team's one-bit full_adder cell across WIDTH cycles to add or subtract two WIDTH-bit operands.
- It owns operand latching, the carry flip-flop, the bit counter, result assembly and a start/busy/done handshake.
- It is the area-minimal alternative to a ripple-carry array, used where throughput is not critical.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = A+B+Cin; 1 = A-B (two's complement; Cin ignored). Latched with start.
- A  input  WIDTH  operand A; latched with start.
- B  input  WIDTH  operand B; latched with start.
- Cin  input  1  carry-in for add; latched with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when results update.
- Sum  output  WIDTH  result; held stable between done pulses.
- Cout  output  1  final carry. For sub, 1 = no borrow (A >= B, unsigned).
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset:
  - On rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, counter=0, internal shift and carry registers=0.
  - Reset mid-RUN aborts the operation. No done pulse is produced, and Sum/Cout/Ovf return to 0.
- States:
  - IDLE: start=1 at edge E0 → RUN.
  - RUN: stay for exactly WIDTH edges, then → DONE.
  - DONE: one cycle. start=1 → RUN; otherwise → IDLE.
  - Encoding is 2-bit binary; illegal state → IDLE.
- Acceptance at E0 (start=1 in IDLE or DONE):
  - Latch opA=A. Latch opB=B when sub=0, or ~B when sub=1.
  - Carry register = Cin when sub=0, or 1 when sub=1.
  - Counter=0. busy=1 from E0.
  - A, B, Cin and sub may change freely after E0.
- RUN, edge Ek (k=1..WIDTH):
  - The full_adder is fed with opA[0], opB[0] and carry.
  - Its Sum bit shifts into the MSB of the partial-result register, which shifts right.
  - opA and opB shift right; carry ← full_adder Cout; counter increments.
  - Bit k-1 is processed at Ek, LSB first.
  - Before updating carry at edge E(WIDTH), capture the old carry as carry-into-MSB.
- Completion at edge E(WIDTH):
  - Sum ← completed partial register; Cout ← final carry; Ovf ← carry-into-MSB XOR final carry.
  - busy=0, done=1 for the following cycle only.
- Latency: done is visible exactly WIDTH cycles after busy rises. Throughput is one operation per WIDTH+1 cycles, because back-to-back start is taken in DONE.
- start while busy=1 is ignored. It is not queued and has no effect on operands or outputs.
- Sum, Cout and Ovf change only at the completion edge or at reset. They never show partial values.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=8, sub=0, A=8'h3C, B=8'h5A, Cin=0, one-cycle start → busy high for 8 cycles, then done pulses once with Sum=8'h96, Cout=0, Ovf=1. Sum stays 0 throughout busy.
- A=8'hFF, B=8'h01, Cin=0 → Sum=8'h00, Cout=1, Ovf=0. Then A=8'h7F, B=8'h00, Cin=1 → Sum=8'h80, Cout=0, Ovf=1.
- sub=1, A=8'h10, B=8'h20, Cin=1 (ignored) → Sum=8'hF0, Cout=0, Ovf=0. Then sub=1, A=8'h80, B=8'h01 → Sum=8'h7F, Cout=1, Ovf=1.
- start with A=8'h01, B=8'h01. Pulse start again at cycle 3 with A=8'hAA, B=8'hAA → the second start is ignored, the result is Sum=8'h02, and exactly one done pulse occurs.
- Hold start=1 continuously with fixed A=8'h05, B=8'h03 → done pulses every 9 cycles with Sum=8'h08, and busy re-asserts on the edge after each done.
- Drive rst_n=0 for one edge at cycle 4 of RUN → busy=0, done never pulses, Sum=0, Cout=0, Ovf=0. A following start/add 8'h02+8'h02 completes normally with Sum=8'h04.
